wb_write_sched: RTL and testbench

//  Write-back scheduler for the Y86 register file, which has a single write port (rf_we/rf_waddr/rf_wdata).

---
 rtl/y86_pkg.sv | 28 ++
 rtl/wb_dst_decode.sv | 30 +++
 rtl/wb_write_sched.sv | 151 +++++++++++++++
 tb/tb_wb_write_sched.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86 write-back definitions: instruction codes, register ids, scheduler states.
package y86_pkg;

    localparam int unsigned NREGS = 15;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] REG_RSP  = 4'd4;
    localparam logic [3:0] REG_NONE = 4'(NREGS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR_E = 2'd1,
        WR_M = 2'd2
    } wb_state_t;

endpackage

// File: rtl/wb_dst_decode.sv
// Destination decode for a retiring instruction: dstE, dstM and illegal-icode flag.
module wb_dst_decode
    import y86_pkg::*;
(
    input  logic [3:0] icode_i,
    input  logic       cnd_i,
    input  logic [3:0] ra_i,
    input  logic [3:0] rb_i,
    output logic [3:0] dst_e_o,
    output logic [3:0] dst_m_o,
    output logic       err_o
);

    // Map icode to its register-file destinations; REG_NONE means no write.
    always_comb begin
        dst_e_o = REG_NONE;
        dst_m_o = REG_NONE;
        err_o   = (icode_i > I_POPQ);
        case (icode_i)
            I_RRMOVQ:                        dst_e_o = cnd_i ? rb_i : REG_NONE;
            I_IRMOVQ, I_OPQ:                 dst_e_o = rb_i;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:  dst_e_o = REG_RSP;
            default:                         dst_e_o = REG_NONE;
        endcase
        if (icode_i == I_MRMOVQ || icode_i == I_POPQ) begin
            dst_m_o = ra_i;
        end
    end

endmodule

// File: rtl/wb_write_sched.sv
// Y86 write-back scheduler: serialises dstE/dstM onto the single register-file write port.
// Optional debug/loader write requester enabled by macro Y86_WB_DBG_EN.
module wb_write_sched
    import y86_pkg::*;
#(
    parameter int unsigned W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wb_valid,
    output logic         wb_ready,
    input  logic [3:0]   wb_icode,
    input  logic         wb_cnd,
    input  logic [3:0]   wb_rA,
    input  logic [3:0]   wb_rB,
    input  logic [W-1:0] wb_valE,
    input  logic [W-1:0] wb_valM,
    output logic         rf_we,
    output logic [3:0]   rf_waddr,
    output logic [W-1:0] rf_wdata,
    output logic         wb_done,
`ifdef Y86_WB_DBG_EN
    input  logic         dbg_req,
    input  logic [3:0]   dbg_addr,
    input  logic [W-1:0] dbg_data,
    output logic         dbg_gnt,
`endif
    output logic         wb_err
);

    wb_state_t      state_q;
    logic [3:0]     dst_m_q;
    logic [W-1:0]   val_m_q;
    logic           rf_we_q;
    logic [3:0]     rf_waddr_q;
    logic [W-1:0]   rf_wdata_q;
    logic           done_q;
    logic           err_q;

    logic [3:0]     dst_e;
    logic [3:0]     dst_m;
    logic           dec_err;
    logic           idle;
    logic           accept;

    wb_dst_decode u_dec (
        .icode_i (wb_icode),
        .cnd_i   (wb_cnd),
        .ra_i    (wb_rA),
        .rb_i    (wb_rB),
        .dst_e_o (dst_e),
        .dst_m_o (dst_m),
        .err_o   (dec_err)
    );

    assign idle   = (state_q == IDLE);
    assign accept = wb_valid && wb_ready;

`ifdef Y86_WB_DBG_EN
    logic last_dbg_q;
    logic dbg_gnt_c;
    logic dbg_wr_c;

    // Debug wins in IDLE unless it also took the previous grant and the pipeline is waiting.
    assign dbg_gnt_c = idle && dbg_req && !(last_dbg_q && wb_valid);
    assign dbg_wr_c  = dbg_gnt_c && (dbg_addr != REG_NONE);
    assign wb_ready  = idle && !dbg_gnt_c;
    assign dbg_gnt   = dbg_gnt_c;
    assign rf_we     = rf_we_q | dbg_wr_c;
    assign rf_waddr  = dbg_wr_c ? dbg_addr : rf_waddr_q;
    assign rf_wdata  = dbg_wr_c ? dbg_data : rf_wdata_q;

    // Remember who owned the last grant for alternating fairness.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_dbg_q <= 1'b0;
        end else if (dbg_gnt_c) begin
            last_dbg_q <= 1'b1;
        end else if (accept) begin
            last_dbg_q <= 1'b0;
        end
    end
`else
    assign wb_ready = idle;
    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
`endif

    assign wb_done = done_q;
    assign wb_err  = err_q;

    // Scheduler FSM; write-port outputs are registered for the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            dst_m_q    <= 4'd0;
            val_m_q    <= W'(0);
            rf_we_q    <= 1'b0;
            rf_waddr_q <= 4'd0;
            rf_wdata_q <= W'(0);
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= 4'd0;
            rf_wdata_q <= W'(0);
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        dst_m_q <= dst_m;
                        val_m_q <= wb_valM;
                        if (dst_e != REG_NONE) begin
                            state_q    <= WR_E;
                            rf_we_q    <= 1'b1;
                            rf_waddr_q <= dst_e;
                            rf_wdata_q <= wb_valE;
                        end else if (dst_m != REG_NONE) begin
                            state_q    <= WR_M;
                            rf_we_q    <= 1'b1;
                            rf_waddr_q <= dst_m;
                            rf_wdata_q <= wb_valM;
                        end else begin
                            done_q <= 1'b1;
                            err_q  <= dec_err;
                        end
                    end
                end
                WR_E: begin
                    if (dst_m_q != REG_NONE) begin
                        state_q    <= WR_M;
                        rf_we_q    <= 1'b1;
                        rf_waddr_q <= dst_m_q;
                        rf_wdata_q <= val_m_q;
                    end else begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                WR_M: begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_write_sched.sv
// Scoreboard bench for wb_write_sched: directed spec cases plus randomized instruction stream.
module tb_wb_write_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid;
    logic        wb_ready;
    logic [3:0]  wb_icode;
    logic        wb_cnd;
    logic [3:0]  wb_rA;
    logic [3:0]  wb_rB;
    logic [63:0] wb_valE;
    logic [63:0] wb_valM;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic        wb_done;
    logic        wb_err;
    logic        dbg_gnt_s;
`ifdef Y86_WB_DBG_EN
    logic        dbg_req;
    logic [3:0]  dbg_addr;
    logic [63:0] dbg_data;
    logic        dbg_gnt;
    assign dbg_gnt_s = dbg_gnt;
`else
    assign dbg_gnt_s = 1'b0;
`endif

    always #5 clk = ~clk;

    wb_write_sched #(.W(64)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_icode (wb_icode),
        .wb_cnd   (wb_cnd),
        .wb_rA    (wb_rA),
        .wb_rB    (wb_rB),
        .wb_valE  (wb_valE),
        .wb_valM  (wb_valM),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .wb_done  (wb_done),
`ifdef Y86_WB_DBG_EN
        .dbg_req  (dbg_req),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .dbg_gnt  (dbg_gnt),
`endif
        .wb_err   (wb_err)
    );

    typedef struct {
        bit          is_done;
        logic [3:0]  addr;
        logic [63:0] data;
        bit          err;
        int          cyc;
    } ev_t;

    ev_t         exp_q[$];
    logic [63:0] shadow [16];
    int          nvec = 0;
    int          nerr = 0;
    int          cyc = 0;
    int          busy = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference destinations straight from the decode table.
    function automatic void model_dst(input logic [3:0] ic, input logic c, input logic [3:0] ra,
                                      input logic [3:0] rb, output logic [3:0] de, output logic [3:0] dm);
        de = 4'hF;
        dm = 4'hF;
        if (ic == 4'h2 && c) de = rb;
        if (ic == 4'h3 || ic == 4'h6) de = rb;
        if (ic >= 4'h8 && ic <= 4'hB) de = 4'h4;
        if (ic == 4'h5 || ic == 4'hB) dm = ra;
    endfunction

    // Queue the writes and completion an accepted instruction must produce; returns write count.
    task automatic push_instr(input logic [3:0] ic, input logic c, input logic [3:0] ra, input logic [3:0] rb,
                              input logic [63:0] ve, input logic [63:0] vm, output int nw);
        logic [3:0] de, dm;
        ev_t e;
        int a;
        a = cyc + 1;
        nw = 0;
        model_dst(ic, c, ra, rb, de, dm);
        if (de != 4'hF) begin
            e = '{is_done: 1'b0, addr: de, data: ve, err: 1'b0, cyc: a + nw};
            exp_q.push_back(e);
            nw++;
        end
        if (dm != 4'hF) begin
            e = '{is_done: 1'b0, addr: dm, data: vm, err: 1'b0, cyc: a + nw};
            exp_q.push_back(e);
            nw++;
        end
        e = '{is_done: 1'b1, addr: 4'h0, data: 64'h0, err: (ic > 4'hB), cyc: a + nw};
        exp_q.push_back(e);
    endtask

    // One cycle of stimulus; checks readiness against the occupancy model.
    task automatic step(input bit v, input logic [3:0] ic, input logic c, input logic [3:0] ra,
                        input logic [3:0] rb, input logic [63:0] ve, input logic [63:0] vm, output bit acc);
        int nw;
        @(negedge clk);
        wb_valid = v;
        wb_icode = ic;
        wb_cnd   = c;
        wb_rA    = ra;
        wb_rB    = rb;
        wb_valE  = ve;
        wb_valM  = vm;
        #1;
        chk("wb_ready", 64'(wb_ready), 64'(busy == 0));
        acc = v && (busy == 0);
        if (busy > 0) begin
            busy--;
        end else if (acc) begin
            push_instr(ic, c, ra, rb, ve, vm, nw);
            busy = nw;
        end
    endtask

    task automatic issue(input logic [3:0] ic, input logic c, input logic [3:0] ra, input logic [3:0] rb,
                         input logic [63:0] ve, input logic [63:0] vm);
        bit acc;
        acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++) step(1'b1, ic, c, ra, rb, ve, vm, acc);
        if (!acc) chk("issue_accept", 64'(acc), 64'd1);
    endtask

    task automatic drain();
        bit acc;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(1'b0, 4'h1, 1'b0, 4'hF, 4'hF, 64'h0, 64'h0, acc);
        step(1'b0, 4'h1, 1'b0, 4'hF, 4'hF, 64'h0, 64'h0, acc);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: pop and compare whenever the DUT presents a write or a completion.
    always begin
        ev_t e;
        @(negedge clk);
        #2;
        if (rst_n) begin
            while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                nvec++;
                nerr++;
                $display("FAIL missing_event: got nothing want %s r%0d=%h at cycle %0d",
                         e.is_done ? "done" : "write", e.addr, e.data, e.cyc);
            end
            if (rf_we && !dbg_gnt_s) begin
                if (exp_q.size() == 0 || exp_q[0].is_done) begin
                    nvec++;
                    nerr++;
                    $display("FAIL wr_unexpected: got write r%0d=%h want none (cycle %0d)", rf_waddr, rf_wdata, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 64'(rf_waddr), 64'(e.addr));
                    chk("wr_data", rf_wdata, e.data);
                    chk("wr_cycle", 64'(cyc), 64'(e.cyc));
                    shadow[rf_waddr] = rf_wdata;
                end
            end else if (!rf_we) begin
                chk("idle_waddr", 64'(rf_waddr), 64'd0);
                chk("idle_wdata", rf_wdata, 64'd0);
            end
            if (wb_done) begin
                if (exp_q.size() == 0 || !exp_q[0].is_done) begin
                    nvec++;
                    nerr++;
                    $display("FAIL done_unexpected: got wb_done=1 want 0 (cycle %0d)", cyc);
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end else begin
                    e = exp_q.pop_front();
                    chk("done_err", 64'(wb_err), 64'(e.err));
                    chk("done_cycle", 64'(cyc), 64'(e.cyc));
                end
            end else begin
                chk("err_without_done", 64'(wb_err), 64'd0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1);
    end

    initial begin
        bit acc;
        logic [3:0] ic;
        for (int i = 0; i < 16; i++) shadow[i] = 64'h0;
        rst_n    = 1'b0;
        wb_valid = 1'b0;
        wb_icode = 4'h1;
        wb_cnd   = 1'b0;
        wb_rA    = 4'hF;
        wb_rB    = 4'hF;
        wb_valE  = 64'h0;
        wb_valM  = 64'h0;
`ifdef Y86_WB_DBG_EN
        dbg_req  = 1'b0;
        dbg_addr = 4'h0;
        dbg_data = 64'h0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_rf_we", 64'(rf_we), 64'd0);
        chk("rst_waddr", 64'(rf_waddr), 64'd0);
        chk("rst_wdata", rf_wdata, 64'd0);
        chk("rst_done", 64'(wb_done), 64'd0);
        chk("rst_err", 64'(wb_err), 64'd0);
        chk("rst_ready", 64'(wb_ready), 64'd1);
        chk("rst_dbg_gnt", 64'(dbg_gnt_s), 64'd0);
        rst_n = 1'b1;

        // irmovq, popq with distinct rA, popq into rsp
        issue(4'h3, 1'b0, 4'hF, 4'h3, 64'h2A, 64'h0);
        drain();
        chk("irmovq_r3", shadow[3], 64'h2A);
        issue(4'hB, 1'b0, 4'h2, 4'hF, 64'h108, 64'h55);
        drain();
        chk("popq_rsp", shadow[4], 64'h108);
        chk("popq_r2", shadow[2], 64'h55);
        shadow[4] = 64'h0;
        issue(4'hB, 1'b0, 4'h4, 4'hF, 64'h108, 64'h55);
        drain();
        chk("popq_rsp_final", shadow[4], 64'h55);

        // No-write instructions back to back, including an illegal icode
        issue(4'h2, 1'b0, 4'h1, 4'h2, 64'h11, 64'h22);
        issue(4'h1, 1'b0, 4'hF, 4'hF, 64'h33, 64'h44);
        issue(4'h4, 1'b0, 4'h1, 4'h2, 64'h55, 64'h66);
        issue(4'hC, 1'b0, 4'h1, 4'h2, 64'h77, 64'h88);
        drain();

        // Async reset during the first write of a popq
        issue(4'hB, 1'b0, 4'h2, 4'hF, 64'h200, 64'h77);
        @(posedge clk);
        #2;
        chk("pre_rst_we", 64'(rf_we), 64'd1);
        chk("pre_rst_addr", 64'(rf_waddr), 64'd4);
        wb_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we", 64'(rf_we), 64'd0);
        chk("mid_rst_ready", 64'(wb_ready), 64'd1);
        exp_q.delete();
        busy = 0;
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, 4'h1, 1'b0, 4'hF, 4'hF, 64'h0, 64'h0, acc);
        chk("post_rst_r2", shadow[2], 64'h55);

        // Randomized instruction stream
        for (int i = 0; i < 400; i++) begin
            ic = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 11));
            step(($urandom_range(0, 3) != 0), ic, 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 {$urandom, $urandom}, {$urandom, $urandom}, acc);
        end
        drain();

`ifdef Y86_WB_DBG_EN
        // Debug and pipeline both requesting: debug, pipeline, debug (addr 15 unwritten)
        begin
            int nw;
            @(negedge clk);
            dbg_req  = 1'b1;
            dbg_addr = 4'h7;
            dbg_data = 64'hDEAD_BEEF;
            wb_valid = 1'b1;
            wb_icode = 4'h3;
            wb_cnd   = 1'b0;
            wb_rA    = 4'hF;
            wb_rB    = 4'h5;
            wb_valE  = 64'h1234;
            wb_valM  = 64'h0;
            #1;
            chk("dbg1_gnt", 64'(dbg_gnt), 64'd1);
            chk("dbg1_we", 64'(rf_we), 64'd1);
            chk("dbg1_addr", 64'(rf_waddr), 64'd7);
            chk("dbg1_data", rf_wdata, 64'hDEAD_BEEF);
            chk("dbg1_ready", 64'(wb_ready), 64'd0);
            @(negedge clk);
            #1;
            chk("dbg2_gnt", 64'(dbg_gnt), 64'd0);
            chk("dbg2_ready", 64'(wb_ready), 64'd1);
            push_instr(4'h3, 1'b0, 4'hF, 4'h5, 64'h1234, 64'h0, nw);
            @(negedge clk);
            #1;
            chk("dbg3_gnt_in_wr", 64'(dbg_gnt), 64'd0);
            chk("dbg3_ready", 64'(wb_ready), 64'd0);
            @(negedge clk);
            dbg_addr = 4'hF;
            #1;
            chk("dbg4_gnt", 64'(dbg_gnt), 64'd1);
            chk("dbg4_we_rnone", 64'(rf_we), 64'd0);
            chk("dbg4_ready", 64'(wb_ready), 64'd0);
            @(negedge clk);
            dbg_req  = 1'b0;
            dbg_addr = 4'h0;
            wb_valid = 1'b0;
            busy = 0;
        end
        drain();
        chk("dbg_pipe_r5", shadow[5], 64'h1234);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
